// File: rtl/bus_memory_pkg.sv
// bus_memory_pkg: shared state encoding and default sizes for bus_memory
package bus_memory_pkg;
  typedef enum logic [1:0] {
    MEM_CLEAR = 2'd0,
    MEM_IDLE  = 2'd1,
    MEM_PROG  = 2'd2
  } mem_state_e;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;
endpackage

// File: rtl/bus_memory_mem_array.sv
// bus_memory_mem_array: DEPTH x DATA_WIDTH storage, one sync write port, one async read port
module bus_memory_mem_array #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge i_clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/bus_memory.sv
// bus_memory: tristate-bus main memory with clear-on-reset sweep and streaming program loader
import bus_memory_pkg::*;
module bus_memory #(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_read_n,
  input  logic                  i_write_n,
  input  logic [ADDR_WIDTH-1:0] i_address,
  inout  wire  [DATA_WIDTH-1:0] io_bus,
  output logic                  o_busy,
  input  logic                  i_prog_en,
  input  logic                  i_prog_valid,
  input  logic [DATA_WIDTH-1:0] i_prog_data,
  output logic                  o_prog_ready,
  output logic [ADDR_WIDTH-1:0] o_prog_addr,
  output logic                  o_prog_full
);
  mem_state_e state;
  logic [ADDR_WIDTH-1:0] ptr, waddr;
  logic [DATA_WIDTH-1:0] wdata, rdata;
  logic prog_full, bus_rd, bus_wr, accept, we;
  always_comb begin
    bus_rd = state == MEM_IDLE && !i_read_n && i_write_n;
    bus_wr = state == MEM_IDLE && !i_write_n && i_read_n;
    accept = state == MEM_PROG && i_prog_en && i_prog_valid && !prog_full;
    we     = !i_reset && (state == MEM_CLEAR || accept || bus_wr);
    waddr  = state == MEM_IDLE ? i_address : ptr;
    wdata  = state == MEM_CLEAR ? '0 : state == MEM_PROG ? i_prog_data : io_bus;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= CLEAR_ON_RESET ? MEM_CLEAR : MEM_IDLE;
      ptr       <= '0;
      prog_full <= 1'b0;
    end else begin
      case (state)
        MEM_CLEAR: begin
          ptr <= ptr + 1'b1;
          if (ptr == '1) state <= MEM_IDLE;
        end
        MEM_IDLE: if (i_prog_en) begin
          state     <= MEM_PROG;
          ptr       <= '0;
          prog_full <= 1'b0;
        end
        MEM_PROG: begin
          if (!i_prog_en) state <= MEM_IDLE;
          else if (accept) begin
            ptr <= ptr + 1'b1;
            if (ptr == '1) prog_full <= 1'b1;
          end
        end
        default: state <= MEM_IDLE;
      endcase
    end
  end
  bus_memory_mem_array #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_mem (
    .i_clk (i_clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (i_address),
    .rdata (rdata)
  );
  assign io_bus       = bus_rd ? rdata : 'z;
  assign o_busy       = state != MEM_IDLE;
  assign o_prog_ready = state == MEM_PROG && !prog_full;
  assign o_prog_addr  = ptr;
  assign o_prog_full  = prog_full;
endmodule

// File: tb/tb_bus_memory.sv
// tb_bus_memory: randomized scoreboard bench for bus_memory against an array reference model
module tb_bus_memory;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b0, read_n = 1'b1, write_n = 1'b1, prog_en = 1'b0, prog_valid = 1'b0, drv_en = 1'b0;
  logic [3:0] addr = '0;
  logic [7:0] prog_data = '0, drv = '0;
  wire  [7:0] io_bus;
  logic busy, ready, full;
  logic [3:0] paddr;
  assign io_bus = drv_en ? drv : 'z;
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (io_bus[g]);
  end
  bus_memory dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_read_n     (read_n),
    .i_write_n    (write_n),
    .i_address    (addr),
    .io_bus       (io_bus),
    .o_busy       (busy),
    .i_prog_en    (prog_en),
    .i_prog_valid (prog_valid),
    .i_prog_data  (prog_data),
    .o_prog_ready (ready),
    .o_prog_addr  (paddr),
    .o_prog_full  (full)
  );
  typedef struct {
    int         cyc;
    int         sel;
    logic [7:0] val;
    int         tst;
  } exp_t;
  exp_t q[$];
  exp_t e;
  logic [7:0] ref_mem [16];
  logic [7:0] act;
  int cyc = 0, checks = 0, errors = 0, tst = 0;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic string sname(int s);
    return s == 0 ? "bus" : s == 1 ? "busy" : s == 2 ? "ready" : s == 3 ? "prog_addr" : "prog_full";
  endfunction
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      act = e.sel == 0 ? io_bus : e.sel == 1 ? {7'd0, busy} : e.sel == 2 ? {7'd0, ready} :
            e.sel == 3 ? {4'd0, paddr} : {7'd0, full};
      checks++;
      if (act !== e.val) begin
        errors++;
        $display("FAIL t%0d %s got=%h want=%h", e.tst, sname(e.sel), act, e.val);
      end
    end
  end
  task automatic chk(input int s, input logic [7:0] v);
    q.push_back('{cyc, s, v, tst});
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    read_n = 1'b1; write_n = 1'b1; drv_en = 1'b0; prog_valid = 1'b0;
  endtask
  task automatic bus_wr(input logic [3:0] a, input logic [7:0] d);
    step(); clr();
    write_n = 1'b0; addr = a; drv = d; drv_en = 1'b1;
    ref_mem[a] = d;
  endtask
  task automatic bus_rd(input logic [3:0] a);
    step(); clr();
    read_n = 1'b0; addr = a;
    chk(0, ref_mem[a]);
  endtask
  task automatic read_all();
    for (int i = 0; i < 16; i++) bus_rd(4'(i));
  endtask
  task automatic clear_phase();
    for (int i = 0; i < 16; i++) begin
      if (i == 8) prog_en = 1'b0;
      chk(1, 8'd1);
      chk(2, 8'd0);
      step();
    end
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    chk(1, 8'd0);
  endtask
  logic [7:0] words [7] = '{8'h1D, 8'h61, 8'h40, 8'h90, 8'hC2, 8'h40, 8'hF0};
  int acc, n;
  initial begin
    tst = 1;
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    chk(3, 8'd0); chk(4, 8'd0); chk(2, 8'd0);
    clear_phase();
    read_all();
    tst = 2;
    bus_wr(4'd13, 8'h3F);
    bus_rd(4'd13);
    step(); clr(); chk(0, 8'hFF);
    tst = 3;
    step(); clr(); prog_en = 1'b1; chk(1, 8'd0);
    for (int i = 0; i < 7; i++) begin
      step(); clr();
      prog_valid = 1'b1; prog_data = words[i];
      chk(3, 8'(i)); chk(2, 8'd1); chk(1, 8'd1);
      ref_mem[i] = words[i];
    end
    step(); clr(); prog_en = 1'b0; prog_valid = 1'b1; prog_data = 8'hAA;
    chk(3, 8'd7); chk(1, 8'd1);
    step(); clr(); chk(1, 8'd0);
    for (int i = 0; i < 8; i++) bus_rd(4'(i));
    tst = 4;
    step(); clr(); prog_en = 1'b1;
    acc = 0; n = 0;
    while (acc < 16 && n < 200) begin
      step(); clr(); n++;
      chk(3, 8'(acc)); chk(2, 8'd1); chk(4, 8'd0);
      prog_data = 8'($urandom);
      if ($urandom_range(0, 2) != 0) begin
        prog_valid = 1'b1;
        ref_mem[acc] = prog_data;
        acc++;
      end
    end
    step(); clr(); prog_valid = 1'b1; prog_data = ~ref_mem[0];
    chk(4, 8'd1); chk(2, 8'd0); chk(3, 8'd0); chk(1, 8'd1);
    step(); clr(); prog_en = 1'b0; prog_valid = 1'b1; prog_data = ~ref_mem[0];
    step(); clr(); chk(1, 8'd0); chk(4, 8'd1);
    read_all();
    tst = 5;
    bus_wr(4'd3, 8'h5A);
    step(); clr(); read_n = 1'b0; write_n = 1'b0; addr = 4'd3; chk(0, 8'hFF);
    bus_rd(4'd3);
    step(); clr(); prog_en = 1'b1;
    step(); clr(); write_n = 1'b0; addr = 4'd3; drv = 8'hC3; drv_en = 1'b1;
    chk(1, 8'd1); chk(4, 8'd0);
    step(); clr(); read_n = 1'b0; addr = 4'd3; chk(0, 8'hFF); prog_en = 1'b0;
    step(); clr();
    bus_rd(4'd3);
    tst = 6;
    step(); clr(); prog_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(); clr(); prog_valid = 1'b1; prog_data = 8'(8'h71 + i);
    end
    step(); clr(); prog_valid = 1'b1; prog_data = 8'hEE; rst = 1'b1;
    step(); clr(); rst = 1'b0;
    chk(3, 8'd0); chk(4, 8'd0);
    clear_phase();
    read_all();
    tst = 7;
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 1) == 0) bus_wr(4'($urandom), 8'($urandom));
      else bus_rd(4'($urandom));
    end
    step(); clr(); prog_en = 1'b1;
    n = $urandom_range(1, 15); acc = 0;
    for (int k = 0; k < 200 && acc < n; k++) begin
      step(); clr();
      chk(3, 8'(acc));
      prog_data = 8'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        prog_valid = 1'b1;
        ref_mem[acc] = prog_data;
        acc++;
      end
    end
    step(); clr(); prog_en = 1'b0; prog_valid = 1'b1; prog_data = 8'($urandom);
    chk(3, 8'(acc));
    step(); clr();
    read_all();
    step(); clr();
    step();
    if (q.size() != 0) begin
      $display("FAIL drain pending=%0d want=0", q.size());
      errors += q.size();
      checks += q.size();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
